// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares the single unified instruction/data memory port of the multicycle
//   MIPS core with a second requester (program loader / DMA engine).
//   Ownership is registered. The last owner stays parked on the port, so the
//   core sees no added latency while it is the only requester. A bounded-burst
//   counter hands the port over after MAX_BURST consecutive grants whenever
//   the other side is waiting.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   c_req/c_we/c_adr/c_wd core request, write flag, address, write data
//   c_gnt, c_rd           core access performed this cycle, read data
//   d_req/d_we/d_adr/d_wd DMA request, write flag, address, write data
//   d_gnt, d_rd           DMA access performed this cycle, read data
//   memwrite/adr/writedata memory write enable, address, write data
//   readdata             memory read data (combinational read of adr)
//   owner                current owner register: 0 = core, 1 = DMA
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_adr,
    input  logic [DW-1:0] c_wd,
    output logic          c_gnt,
    output logic [DW-1:0] c_rd,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_adr,
    input  logic [DW-1:0] d_wd,
    output logic          d_gnt,
    output logic [DW-1:0] d_rd,

    output logic          memwrite,
    output logic [AW-1:0] adr,
    output logic [DW-1:0] writedata,
    input  logic [DW-1:0] readdata,

    output logic          owner
);

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } own_t;

    // Last burst index: when bcnt reaches this value under contention the
    // owner is taking its MAX_BURST-th grant and must hand over at the edge.
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    own_t       own_q;
    own_t       own_nxt;
    logic [7:0] bcnt_q;
    logic [7:0] bcnt_nxt;

    logic       o_req;
    logic       x_req;
    own_t       other;

    // State register: owner and burst counter
    always_ff @(posedge clk) begin
        if (reset) begin
            own_q  <= OWN_CORE;
            bcnt_q <= 8'd0;
        end else begin
            own_q  <= own_nxt;
            bcnt_q <= bcnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        own_nxt  = own_q;
        bcnt_nxt = 8'd0;
        o_req    = (own_q == OWN_CORE) ? c_req : d_req;
        x_req    = (own_q == OWN_CORE) ? d_req : c_req;
        other    = (own_q == OWN_CORE) ? OWN_DMA : OWN_CORE;

        if (!x_req) begin
            // Nobody waiting: park on the current owner.
            own_nxt  = own_q;
            bcnt_nxt = 8'd0;
        end else if (!o_req) begin
            // Owner idle, other side waiting: switch. The waiter is not
            // granted in this cycle because the port still follows own_q.
            own_nxt  = other;
            bcnt_nxt = 8'd0;
        end else if (bcnt_q == BURST_LAST) begin
            // Owner takes its last grant of the burst now; hand over.
            own_nxt  = other;
            bcnt_nxt = 8'd0;
        end else begin
            own_nxt  = own_q;
            bcnt_nxt = bcnt_q + 8'd1;
        end
    end

    // Port steering: address and write data always follow the owner, even
    // when it is not requesting, so an idle port points at the parked owner.
    always_comb begin
        c_gnt     = c_req & (own_q == OWN_CORE);
        d_gnt     = d_req & (own_q == OWN_DMA);
        memwrite  = (c_gnt & c_we) | (d_gnt & d_we);
        adr       = (own_q == OWN_CORE) ? c_adr : d_adr;
        writedata = (own_q == OWN_CORE) ? c_wd  : d_wd;
        c_rd      = c_gnt ? readdata : '0;
        d_rd      = d_gnt ? readdata : '0;
    end

    assign owner = own_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory port of the multicycle MIPS core with a second requester, the program loader / DMA engine.
- Sits between the `mips` top and the memory. It drives the memory address, write data and write enable, and returns read data to whichever requester currently holds the grant.
- Uses registered ownership with parking, plus a bounded-burst fairness rule, so the core sees zero added latency when it is the only requester.

Parameters:
- AW, 32, address width of both requesters and the memory port.
- DW, 32, data width.
- MAX_BURST, 8, max consecutive granted cycles for one owner while the other requester is waiting (legal range 1..255).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- c_req  input  1  core requests a memory access this cycle.
- c_we  input  1  core access is a write.
- c_adr  input  AW  core address.
- c_wd  input  DW  core write data.
- c_gnt  output  1  core access performed this cycle.
- c_rd  output  DW  read data to core.
- d_req  input  1  DMA requests an access.
- d_we  input  1  DMA access is a write.
- d_adr  input  AW  DMA address.
- d_wd  input  DW  DMA write data.
- d_gnt  output  1  DMA access performed this cycle.
- d_rd  output  DW  read data to DMA.
- memwrite  output  1  memory write enable.
- adr  output  AW  memory address.
- writedata  output  DW  memory write data.
- readdata  input  DW  memory read data (combinational read of `adr`).
- owner  output  1  current owner register: 0 = core, 1 = DMA.

Behaviour:
Registered state:
- `owner` (1 bit) and `bcnt` (8 bits).
- Reset, applied at the clock edge while reset=1: owner=0 (core), bcnt=0.

Combinational outputs, every cycle:
- c_gnt = c_req & (owner==0); d_gnt = d_req & (owner==1).
- adr/writedata come from the owner's inputs regardless of its request.
- memwrite = (c_gnt & c_we) | (d_gnt & d_we). It is never 1 without a grant.
- c_rd = c_gnt ? readdata : 0; d_rd = d_gnt ? readdata : 0.
- During reset: owner=0 after the first edge, so c_gnt follows c_req and d_gnt=0.

Handshake:
- An access completes in exactly the cycle its gnt=1.
- A requester holds req/we/adr/wd stable until it sees gnt.
- A requester without ownership waits at least 1 cycle (the switch cycle).
- The core stall is its own logic: the core's pcen/irwrite/memwrite are qualified by c_gnt in `mips`.

Next-state rules, with o = owner and x = non-owner:
- x_req=0: owner holds (parking); bcnt<=0.
- o_req=0 and x_req=1: owner<=x; bcnt<=0. No grant is issued to x this cycle.
- o_req=1 and x_req=1 and bcnt<MAX_BURST-1: owner holds; bcnt<=bcnt+1.
- o_req=1 and x_req=1 and bcnt==MAX_BURST-1: owner<=x; bcnt<=0. Owner o receives its MAX_BURST-th grant this cycle.
- Result under continuous contention: strict alternation of MAX_BURST grants each, with no idle cycle, since the new owner is granted on the first cycle after the switch edge.
- bcnt never exceeds MAX_BURST-1, so there is no wrap-around.

Boundary conditions:
- Simultaneous first requests from idle: the current parked owner wins.
- Both requesters idle: no memory write; adr follows the parked owner.
- Reset mid-access: any granted write in the reset cycle still occurs (combinational). Ownership returns to core at the edge; bcnt clears.
- MAX_BURST=1: owner alternates every contended cycle.

Test Plan:
- Reset then c_req=1 only, c_adr=0x00,0x04,0x08 -> c_gnt=1 in each cycle, owner=0 throughout, adr matches, d_gnt=0.
- Core parked, idle. Raise d_req=1, d_we=1, d_adr=0x100, d_wd=0xDEADBEEF -> cycle 0: d_gnt=0, memwrite=0. Edge: owner=1. Cycle 1: d_gnt=1, memwrite=1, adr=0x100. A following core read of 0x100 returns 0xDEADBEEF.
- MAX_BURST=8, c_req and d_req both held high from owner=0 -> c_gnt high for 8 cycles, then d_gnt high for 8 cycles, repeating. Exactly one gnt per cycle; owner toggles every 8 edges.
- DMA owner, d_req drops while c_req=1 -> one cycle with both gnt=0, then c_gnt=1 next cycle; bcnt=0.
- Assert reset during a DMA burst (owner=1, bcnt=5) -> after the edge owner=0, bcnt=0, d_gnt=0. The core is granted while c_req=1.
- MAX_BURST=1 with both requesting -> grants alternate core, DMA, core, DMA each cycle; memwrite only when the granted requester's we=1.
